// File: rtl/frame_mapping_pkg.sv
// frame_mapping_pkg: shared definitions for the receive-side frame mapping block.
//   - descriptor field offsets and widths
//   - mapping-table entry field offsets
//   - lookup FSM state encoding
//   - entry_hit(): decides whether a table entry matches a descriptor
// Build option: define FLOW_HASH_CHECK_EN to make a hit also require that the
// 13-bit flow check hash matches. Left undefined, only the entry valid bit counts.
package frame_mapping_pkg;

  // Descriptor layout
  localparam int DESC_W     = 32;
  localparam int BUFID_LSB  = 0;
  localparam int BUFID_W    = 9;
  localparam int IDX_LSB    = 9;
  localparam int IDX_W      = 8;
  localparam int DHASH_LSB  = 17;
  localparam int HASH_W     = 13;
  localparam int MAPREQ_BIT = 30;
  localparam int RSVD_BIT   = 31;

  // Mapping-table entry layout
  localparam int ENTRY_W    = 62;
  localparam int VALID_BIT  = 61;
  localparam int TAG_MSB    = 60;
  localparam int TAG_LSB    = 13;
  localparam int TAG_W      = TAG_MSB - TAG_LSB + 1;

`ifdef FLOW_HASH_CHECK_EN
  localparam logic HASH_CHECK_ON = 1'b1;
`else
  localparam logic HASH_CHECK_ON = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_CMP  = 3'd3,
    ST_OUT  = 3'd4
  } state_e;

  // The hash compare is always computed; HASH_CHECK_ON decides whether it gates the hit.
  function automatic logic entry_hit(input logic [ENTRY_W-1:0] entry,
                                     input logic [HASH_W-1:0]  hash);
    logic hash_eq;
    hash_eq = (entry[HASH_W-1:0] == hash);
    return entry[VALID_BIT] & (~HASH_CHECK_ON | hash_eq);
  endfunction

endpackage

// File: rtl/lookup_mapping_table.sv
// lookup_mapping_table: per-descriptor lookup FSM (IDLE, RD, WAIT, CMP, OUT).
//   iv_descriptor/i_descriptor_wr/o_descriptor_ready : upstream handshake
//   o_ram_rden/ov_ram_addr/iv_ram_q                   : RAM port-B lookup
//   ov_tsntag/ov_bufid/o_match_flag/o_replace_flag    : held results
//   o_descriptor_wr/i_descriptor_ready                : downstream handshake
// One descriptor is in flight at a time. Results hold between pulses.
module lookup_mapping_table
  import frame_mapping_pkg::*;
#(
  parameter int RAM_RD_LAT = 2,
  parameter int TBL_AW     = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [DESC_W-1:0]  iv_descriptor,
  input  logic               i_descriptor_wr,
  output logic               o_descriptor_ready,
  output logic               o_ram_rden,
  output logic [TBL_AW-1:0]  ov_ram_addr,
  input  logic [ENTRY_W-1:0] iv_ram_q,
  output logic [TAG_W-1:0]   ov_tsntag,
  output logic [BUFID_W-1:0] ov_bufid,
  output logic               o_match_flag,
  output logic               o_replace_flag,
  output logic               o_descriptor_wr,
  input  logic               i_descriptor_ready
);

  // Last WAIT cycle; with a 1-cycle RAM the WAIT state is skipped entirely.
  localparam logic [1:0] WAIT_LAST = 2'(RAM_RD_LAT - 2);

  state_e             state_r;
  logic               ready_r;
  logic               rden_r;
  logic [1:0]         wait_cnt_r;
  logic [TBL_AW-1:0]  idx_r;
  logic [HASH_W-1:0]  hash_r;
  logic [TAG_W-1:0]   tsntag_r;
  logic [BUFID_W-1:0] bufid_r;
  logic               match_r;
  logic               replace_r;
  logic               wr_r;
  logic               hit_s;
  logic               unused_rsvd_s;

  assign hit_s         = entry_hit(iv_ram_q, hash_r);
  assign unused_rsvd_s = iv_descriptor[RSVD_BIT];

  // Lookup FSM with registered handshake, RAM strobe and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      ready_r    <= 1'b1;
      rden_r     <= 1'b0;
      wait_cnt_r <= 2'd0;
      idx_r      <= '0;
      hash_r     <= '0;
      tsntag_r   <= '0;
      bufid_r    <= '0;
      match_r    <= 1'b0;
      replace_r  <= 1'b0;
      wr_r       <= 1'b0;
    end else begin
      wr_r   <= 1'b0;
      rden_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_descriptor_wr) begin
            bufid_r <= iv_descriptor[BUFID_LSB +: BUFID_W];
            idx_r   <= iv_descriptor[IDX_LSB +: TBL_AW];
            hash_r  <= iv_descriptor[DHASH_LSB +: HASH_W];
            ready_r <= 1'b0;
            if (iv_descriptor[MAPREQ_BIT]) begin
              rden_r  <= 1'b1;
              state_r <= ST_RD;
            end else begin
              tsntag_r  <= '0;
              match_r   <= 1'b0;
              replace_r <= 1'b0;
              state_r   <= ST_OUT;
            end
          end
        end
        ST_RD: begin
          wait_cnt_r <= 2'd0;
          if (RAM_RD_LAT > 1) begin
            state_r <= ST_WAIT;
          end else begin
            state_r <= ST_CMP;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r == WAIT_LAST) begin
            state_r <= ST_CMP;
          end else begin
            wait_cnt_r <= wait_cnt_r + 2'd1;
          end
        end
        ST_CMP: begin
          tsntag_r  <= hit_s ? iv_ram_q[TAG_MSB:TAG_LSB] : '0;
          match_r   <= hit_s;
          replace_r <= hit_s;
          state_r   <= ST_OUT;
        end
        ST_OUT: begin
          // Ready rises together with the pulse so the next accept can follow at once.
          if (i_descriptor_ready) begin
            wr_r    <= 1'b1;
            ready_r <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Ready is forced low while reset is held and comes up in the first cycle after it.
  assign o_descriptor_ready = ready_r & ~i_rst;
  assign o_ram_rden         = rden_r;
  assign ov_ram_addr        = idx_r;
  assign ov_tsntag          = tsntag_r;
  assign ov_bufid           = bufid_r;
  assign o_match_flag       = match_r;
  assign o_replace_flag     = replace_r;
  assign o_descriptor_wr    = wr_r;

endmodule

// File: rtl/ram_62_256.sv
// ram_62_256: dual-port mapping-table RAM (62 bits x 256 entries).
//   Port A: CPU config read/write (iv_a_addr, iv_a_wdata, i_a_wr, i_a_rd -> ov_a_q)
//   Port B: lookup read          (iv_b_addr, i_b_rd -> ov_b_q)
//   Read data appears RD_LAT (1 or 2) cycles after the read strobe and holds
//   until the next read. A same-cycle write and read of one address returns
//   the old contents. i_rst clears only the read pipelines, never the storage.
module ram_62_256 #(
  parameter int RD_LAT = 2,
  parameter int AW     = 8,
  parameter int DW     = 62
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [AW-1:0] iv_a_addr,
  input  logic [DW-1:0] iv_a_wdata,
  input  logic          i_a_wr,
  input  logic          i_a_rd,
  output logic [DW-1:0] ov_a_q,
  input  logic [AW-1:0] iv_b_addr,
  input  logic          i_b_rd,
  output logic [DW-1:0] ov_b_q
);

  logic [DW-1:0] mem_r [2**AW];
  logic [DW-1:0] a_s1_r;
  logic [DW-1:0] b_s1_r;

  // Storage write through port A; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_a_wr) begin
      mem_r[iv_a_addr] <= iv_a_wdata;
    end
  end

  // First read stage for both ports.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_s1_r <= '0;
      b_s1_r <= '0;
    end else begin
      if (i_a_rd) begin
        a_s1_r <= mem_r[iv_a_addr];
      end
      if (i_b_rd) begin
        b_s1_r <= mem_r[iv_b_addr];
      end
    end
  end

  generate
    if (RD_LAT >= 2) begin : g_lat2
      logic [DW-1:0] a_s2_r;
      logic [DW-1:0] b_s2_r;

      // Second (output) read stage.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          a_s2_r <= '0;
          b_s2_r <= '0;
        end else begin
          a_s2_r <= a_s1_r;
          b_s2_r <= b_s1_r;
        end
      end

      assign ov_a_q = a_s2_r;
      assign ov_b_q = b_s2_r;
    end else begin : g_lat1
      assign ov_a_q = a_s1_r;
      assign ov_b_q = b_s1_r;
    end
  endgenerate

endmodule

// File: rtl/frame_mapping.sv
// frame_mapping: receive-side flow-index to TSNTag mapping.
//   Descriptor in  : iv_descriptor, i_descriptor_wr, o_descriptor_ready
//   Result out     : ov_tsntag, ov_bufid, o_lookup_table_match_flag,
//                    o_tsntag_replace_flag, o_descriptor_wr, i_descriptor_ready
//   Config port    : iv_map_ram_wdata, i_map_ram_wr, iv_map_ram_addr,
//                    i_map_ram_rd, ov_map_ram_rdata (RAM port A)
// Build option: FLOW_HASH_CHECK_EN adds the flow hash compare to the hit test.
module frame_mapping
  import frame_mapping_pkg::*;
#(
  parameter int RAM_RD_LAT = 2,
  parameter int TBL_AW     = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [DESC_W-1:0]  iv_descriptor,
  input  logic               i_descriptor_wr,
  output logic               o_descriptor_ready,
  input  logic [ENTRY_W-1:0] iv_map_ram_wdata,
  input  logic               i_map_ram_wr,
  input  logic [TBL_AW-1:0]  iv_map_ram_addr,
  output logic [ENTRY_W-1:0] ov_map_ram_rdata,
  input  logic               i_map_ram_rd,
  output logic [TAG_W-1:0]   ov_tsntag,
  output logic [BUFID_W-1:0] ov_bufid,
  output logic               o_lookup_table_match_flag,
  output logic               o_tsntag_replace_flag,
  output logic               o_descriptor_wr,
  input  logic               i_descriptor_ready
);

  logic               map_rd_en_s;
  logic [TBL_AW-1:0]  map_rd_addr_s;
  logic [ENTRY_W-1:0] map_rd_q_s;

  lookup_mapping_table #(
    .RAM_RD_LAT (RAM_RD_LAT),
    .TBL_AW     (TBL_AW)
  ) u_lookup (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .iv_descriptor      (iv_descriptor),
    .i_descriptor_wr    (i_descriptor_wr),
    .o_descriptor_ready (o_descriptor_ready),
    .o_ram_rden         (map_rd_en_s),
    .ov_ram_addr        (map_rd_addr_s),
    .iv_ram_q           (map_rd_q_s),
    .ov_tsntag          (ov_tsntag),
    .ov_bufid           (ov_bufid),
    .o_match_flag       (o_lookup_table_match_flag),
    .o_replace_flag     (o_tsntag_replace_flag),
    .o_descriptor_wr    (o_descriptor_wr),
    .i_descriptor_ready (i_descriptor_ready)
  );

  ram_62_256 #(
    .RD_LAT (RAM_RD_LAT),
    .AW     (TBL_AW),
    .DW     (ENTRY_W)
  ) u_ram (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .iv_a_addr  (iv_map_ram_addr),
    .iv_a_wdata (iv_map_ram_wdata),
    .i_a_wr     (i_map_ram_wr),
    .i_a_rd     (i_map_ram_rd),
    .ov_a_q     (ov_map_ram_rdata),
    .iv_b_addr  (map_rd_addr_s),
    .i_b_rd     (map_rd_en_s),
    .ov_b_q     (map_rd_q_s)
  );

endmodule

// File: tb/tb_frame_mapping.sv
// tb_frame_mapping: directed plus randomized test of frame_mapping against a
// table model kept in the bench.
module tb_frame_mapping;
  localparam int RD_LAT = 2;
`ifdef FLOW_HASH_CHECK_EN
  localparam bit HASH_CHK = 1'b1;
`else
  localparam bit HASH_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iv_descriptor;
  logic        i_descriptor_wr;
  logic        o_descriptor_ready;
  logic [61:0] iv_map_ram_wdata;
  logic        i_map_ram_wr;
  logic [7:0]  iv_map_ram_addr;
  logic [61:0] ov_map_ram_rdata;
  logic        i_map_ram_rd;
  logic [47:0] ov_tsntag;
  logic [8:0]  ov_bufid;
  logic        o_match;
  logic        o_replace;
  logic        o_descriptor_wr;
  logic        i_descriptor_ready;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [61:0] model_mem [256];

  always #5 clk = ~clk;

  frame_mapping dut (
    .i_clk                     (clk),
    .i_rst                     (rst),
    .iv_descriptor             (iv_descriptor),
    .i_descriptor_wr           (i_descriptor_wr),
    .o_descriptor_ready        (o_descriptor_ready),
    .iv_map_ram_wdata          (iv_map_ram_wdata),
    .i_map_ram_wr              (i_map_ram_wr),
    .iv_map_ram_addr           (iv_map_ram_addr),
    .ov_map_ram_rdata          (ov_map_ram_rdata),
    .i_map_ram_rd              (i_map_ram_rd),
    .ov_tsntag                 (ov_tsntag),
    .ov_bufid                  (ov_bufid),
    .o_lookup_table_match_flag (o_match),
    .o_tsntag_replace_flag     (o_replace),
    .o_descriptor_wr           (o_descriptor_wr),
    .i_descriptor_ready        (i_descriptor_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] make_desc(input logic [8:0] bufid, input logic [7:0] idx,
                                            input logic [12:0] hash, input logic map_req);
    return {1'b0, map_req, hash, idx, bufid};
  endfunction

  function automatic logic [61:0] make_entry(input logic valid, input logic [47:0] tag,
                                             input logic [12:0] hash);
    return {valid, tag, hash};
  endfunction

  // Table rule: an entry hits when valid and (if hash checking is built in) hashes agree.
  function automatic bit model_hit(input logic [61:0] e, input logic [12:0] h);
    if (e[61] == 1'b0) return 1'b0;
    if (HASH_CHK && (e[12:0] != h)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [61:0] rand_entry();
    logic [47:0] t;
    t = {16'($urandom), 32'($urandom)};
    return make_entry(1'($urandom_range(0, 3) != 0), t, 13'($urandom));
  endfunction

  task automatic cfg_write(input logic [7:0] addr, input logic [61:0] data);
    iv_map_ram_addr = addr; iv_map_ram_wdata = data; i_map_ram_wr = 1'b1;
    @(posedge clk); #1;
    i_map_ram_wr = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic cfg_read(input logic [7:0] addr);
    iv_map_ram_addr = addr; i_map_ram_rd = 1'b1;
    @(posedge clk); #1;
    i_map_ram_rd = 1'b0;
    repeat (RD_LAT - 1) begin @(posedge clk); #1; end
    check("cfg_rdata", 64'(ov_map_ram_rdata), 64'(model_mem[addr]));
  endtask

  // Send one descriptor with downstream ready and check the single result pulse.
  task automatic run_desc(input logic [31:0] desc);
    logic [61:0] e;
    logic        hit;
    int          exp_lat, lat, rd_cnt;
    bit          got;
    e       = model_mem[desc[16:9]];
    hit     = desc[30] && model_hit(e, desc[29:17]);
    exp_lat = desc[30] ? 2 + RD_LAT : 1;
    check("ready_before_accept", 64'(o_descriptor_ready), 64'd1);
    iv_descriptor = desc; i_descriptor_wr = 1'b1;
    @(posedge clk); #1;
    i_descriptor_wr = 1'b0;
    check("ready_busy", 64'(o_descriptor_ready), 64'd0);
    rd_cnt = int'(dut.map_rd_en_s);
    lat = 0; got = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      rd_cnt += int'(dut.map_rd_en_s);
      if (o_descriptor_wr) begin
        lat = k; got = 1'b1;
        break;
      end
    end
    check("wr_seen", 64'(got), 64'd1);
    check("latency", 64'(lat), 64'(exp_lat));
    check("tsntag", 64'(ov_tsntag), hit ? 64'(e[60:13]) : 64'd0);
    check("bufid", 64'(ov_bufid), 64'(desc[8:0]));
    check("match", 64'(o_match), 64'(hit));
    check("replace", 64'(o_replace), 64'(hit));
    check("rden_pulses", 64'(rd_cnt), desc[30] ? 64'd1 : 64'd0);
    @(posedge clk); #1;
    check("wr_single", 64'(o_descriptor_wr), 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [61:0] e5;
    rst = 1'b1; iv_descriptor = 32'd0; i_descriptor_wr = 1'b0;
    iv_map_ram_wdata = 62'd0; i_map_ram_wr = 1'b0; iv_map_ram_addr = 8'd0;
    i_map_ram_rd = 1'b0; i_descriptor_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(o_descriptor_ready), 64'd0);
    check("rst_wr", 64'(o_descriptor_wr), 64'd0);
    check("rst_tag", 64'(ov_tsntag), 64'd0);
    check("rst_flags", 64'({o_match, o_replace, ov_bufid}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 64'(o_descriptor_ready), 64'd1);

    for (int a = 0; a < 256; a++) cfg_write(8'(a), rand_entry());
    e5 = make_entry(1'b1, 48'h0011_2233_4455, 13'h0ABC);
    cfg_write(8'h05, e5);
    cfg_write(8'h06, make_entry(1'b0, 48'hA5A5_5A5A_1234, 13'h0ABC));

    // Hit, miss on valid, hash mismatch, bypass
    run_desc(make_desc(9'h123, 8'h05, 13'h0ABC, 1'b1));
    check("hit_tag_const", 64'(ov_tsntag), 64'h0000_0011_2233_4455);
    run_desc(make_desc(9'h055, 8'h06, 13'h0ABC, 1'b1));
    run_desc(make_desc(9'h1C3, 8'h05, 13'h0ABD, 1'b1));
    run_desc(make_desc(9'h0FF, 8'h05, 13'h0ABC, 1'b0));

    // Backpressure in OUT for 10+ cycles
    i_descriptor_ready = 1'b0;
    iv_descriptor = make_desc(9'h0AA, 8'h05, 13'h0ABC, 1'b1); i_descriptor_wr = 1'b1;
    @(posedge clk); #1;
    i_descriptor_wr = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      check("bp_wr_low", 64'(o_descriptor_wr), 64'd0);
      check("bp_ready_low", 64'(o_descriptor_ready), 64'd0);
      if (k >= 3) begin
        check("bp_tag_hold", 64'(ov_tsntag), 64'h0000_0011_2233_4455);
        check("bp_match_hold", 64'(o_match), 64'd1);
      end
    end
    i_descriptor_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_pulse", 64'(o_descriptor_wr), 64'd1);
    check("bp_bufid", 64'(ov_bufid), 64'h0AA);
    @(posedge clk); #1;
    check("bp_pulse_end", 64'(o_descriptor_wr), 64'd0);
    check("bp_ready_back", 64'(o_descriptor_ready), 64'd1);

    // Reset while waiting on the RAM
    iv_descriptor = make_desc(9'h111, 8'h05, 13'h0ABC, 1'b1); i_descriptor_wr = 1'b1;
    @(posedge clk); #1;
    i_descriptor_wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("wrst_ready", 64'(o_descriptor_ready), 64'd0);
    check("wrst_outs", 64'({o_descriptor_wr, o_match, o_replace, ov_bufid}), 64'd0);
    check("wrst_tag", 64'(ov_tsntag), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("wrst_ready_after", 64'(o_descriptor_ready), 64'd1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("wrst_no_wr", 64'(o_descriptor_wr), 64'd0);
    end
    cfg_read(8'h05);

    // Randomized traffic against the table model
    for (int it = 0; it < 60; it++) begin
      logic [7:0]  ri;
      logic [12:0] rh;
      ri = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) cfg_write(ri, rand_entry());
      rh = ($urandom_range(0, 1) == 1) ? model_mem[ri][12:0] : 13'($urandom);
      d  = make_desc(9'($urandom), ri, rh, 1'($urandom_range(0, 3) != 0));
      run_desc(d);
      if ((it % 8) == 0) cfg_read(8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
